data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//  Target side of the SRAM-like data bus that the EX stage drives. Accepts
//  req/addr_ok handshakes into an in-order outstanding queue. Performs each
//  access on an internal word-addressed memory after a fixed latency.
//  Returns one data_ok pulse plus rdata per accepted request, in acceptance order.
//  Used as the data-side memory model in core-level simulation.
// PARAMETERS
//  ADDR_WIDTH  10  word-index bits; memory holds 2**ADDR_WIDTH 32-bit words
//  DEPTH        2  max outstanding (accepted, not yet responded) requests, >=1
//  LATENCY      2  cycles from accept cycle to data_ok cycle, >=2
// PORTS
//  clk                1  in   single clock, all state on posedge
//  resetn             1  in   synchronous active-low reset
//  data_sram_req      1  in   request valid
//  data_sram_wr       1  in   1=write, 0=read
//  data_sram_size     2  in   0=byte 1=half 2=word; stored, not used for data path
//  data_sram_wstrb    4  in   byte enables for writes
//  data_sram_addr    32  in   byte address
//  data_sram_wdata   32  in   write data, already lane-replicated by requester
//  resp_stall         1  in   bench backpressure; forces addr_ok low
//  data_sram_addr_ok  1  out  request accepted this cycle when req & addr_ok
//  data_sram_data_ok  1  out  one-cycle response pulse, registered
//  data_sram_rdata   32  out  read data, valid only with data_ok; registered
// BEHAVIOUR
//  Reset:
//  - data_ok=0 and rdata=0.
//  - Queue emptied: count=0, head/tail pointers=0.
//  - Memory array is NOT reset.
//  addr_ok:
//  - Combinational: addr_ok = (count != DEPTH) & ~resp_stall. Independent of req.
//  - When full, addr_ok stays 0 even if a retire happens in the same cycle.
//  Accept:
//  - Condition: req & addr_ok in cycle c.
//  - Enqueue {wr, size, wstrb, wdata, word index = addr[ADDR_WIDTH+1:2]}.
//  - Address bits above ADDR_WIDTH+1 are ignored (aliasing wrap-around).
//  - addr[1:0] is ignored; lanes are selected only by wstrb.
//  Timing:
//  - data_ok is high exactly in cycle c+LATENCY when the queue ahead is clear.
//  - Otherwise data_ok is high in the cycle after the previous response.
//  - At most one data_ok per cycle; back-to-back accepts give back-to-back data_ok.
//  - Every queued entry ages in parallel (per-entry saturating age counter).
//  Retire:
//  - The head retires at the posedge ending cycle c+LATENCY-1.
//  - On that edge: data_ok<=1, head pointer advances, count decrements.
//  - Same-edge enqueue and retire leaves count unchanged.
//  - Pointers wrap modulo DEPTH.
//  Data path:
//  - Read: rdata <= mem[idx], using memory state after all earlier-queued writes.
//  - Write: for each byte b with wstrb[b]=1, mem[idx] byte b <= wdata byte b.
//  - Write is applied on the retire edge; rdata <= 0 for write responses.
//  - A write with wstrb=0 leaves memory unchanged and still returns data_ok.
//  - Read-after-write to the same word is always ordered, because retire is in order.
//  Otherwise data_ok<=0 and rdata holds its last value.
//  No flush or cancel: every accepted request gets exactly one data_ok, unless reset.
//  Reset mid-operation:
//  - All outstanding entries are dropped with no data_ok.
//  - Writes already retired persist in memory.
//  - addr_ok may go high in the first cycle after reset release.
//  Widths:
//  - count is $clog2(DEPTH+1) bits.
//  - Age counters are $clog2(LATENCY+1) bits and saturate at LATENCY.
// TESTING
//  T1 (default params):
//   - Stimulus: write 0x12345678 to 0x100 with wstrb=1111 in cycle 0, then read
//     0x100 in cycle 1.
//   - Response: data_ok in cycles 2 and 3; rdata=0 in cycle 2, rdata=0x12345678
//     in cycle 3.
//  T2 (after T1):
//   - Stimulus: write 0xAAAAAAAA to 0x102 with wstrb=0010, then read 0x100.
//   - Response: read returns 0x1234AA78.
//  T3 (LATENCY=4, DEPTH=2):
//   - Stimulus: requests A, B, C held from cycle 0.
//   - Response: A accepted c0, B accepted c1, addr_ok=0 in c2..c3, C accepted c4.
//   - data_ok for A in c4, B in c5, C in c8.
//  T4:
//   - Stimulus: resp_stall=1 with req=1 for 3 cycles.
//   - Response: addr_ok=0 and no data_ok; after resp_stall drops, the request is
//     accepted that cycle and data_ok arrives 2 cycles later.
//  T5:
//   - Stimulus: write 0xCAFEF00D to 0x40 and let it retire; then issue 2 reads
//     and assert resetn=0 for 1 cycle.
//   - Response: no data_ok after reset; addr_ok=1 after release; a new read of
//     0x40 returns 0xCAFEF00D.
//  T6 (ADDR_WIDTH=10):
//   - Stimulus: write 0x11111111 to 0x1000, then read 0x0.
//   - Response: rdata=0x11111111 (aliasing).

Source files
------------

// File: rtl/data_sram_if.sv
// SRAM-like data bus between the EX-stage requester and the data memory.
//   master : requester side (drives req/wr/size/wstrb/addr/wdata)
//   slave  : responder side (drives addr_ok/data_ok/rdata)
interface data_sram_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side memory model for core-level simulation.
// Accepts req/addr_ok handshakes into an in-order queue of up to DEPTH
// outstanding requests, performs each access on a word-addressed memory of
// 2**ADDR_WIDTH 32-bit words, and returns one registered data_ok/rdata per
// request LATENCY cycles after acceptance (or the cycle after the previous
// response when the queue ahead is still draining).
// Ports:
//   clk        - clock, all state on posedge
//   resetn     - synchronous active-low reset (memory contents are kept)
//   resp_stall - backpressure, forces addr_ok low
//   bus        - data_sram_if slave modport (request in, addr_ok/data_ok/rdata out)
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 2,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        resp_stall,
  data_sram_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(LATENCY + 1);
  localparam int WORDS = 2 ** ADDR_WIDTH;

  logic [31:0]           mem     [WORDS];

  logic                  q_wr    [DEPTH];
  logic [1:0]            q_size  [DEPTH];
  logic [3:0]            q_wstrb [DEPTH];
  logic [31:0]           q_wdata [DEPTH];
  logic [ADDR_WIDTH-1:0] q_idx   [DEPTH];
  logic [AGE_W-1:0]      q_age   [DEPTH];

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  addr_ok;
  logic                  accept;
  logic                  retire;
  logic                  data_ok_q;
  logic [31:0]           rdata_q;
  logic                  unused_bits;

  assign addr_ok = (count != CNT_W'(DEPTH)) & ~resp_stall;
  assign accept  = bus.data_sram_req & addr_ok;
  // Age is 1 in the cycle after acceptance, so LATENCY-1 marks the last
  // cycle before the response cycle.
  assign retire  = (count != '0) && (q_age[head] >= AGE_W'(LATENCY - 1));

  assign bus.data_sram_addr_ok = addr_ok;
  assign bus.data_sram_data_ok = data_ok_q;
  assign bus.data_sram_rdata   = rdata_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Queue control, per-entry ageing and registered response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (accept && (tail == PTR_W'(i))) begin
          q_wr[i]    <= bus.data_sram_wr;
          q_size[i]  <= bus.data_sram_size;
          q_wstrb[i] <= bus.data_sram_wstrb;
          q_wdata[i] <= bus.data_sram_wdata;
          q_idx[i]   <= bus.data_sram_addr[ADDR_WIDTH+1:2];
          q_age[i]   <= AGE_W'(1);
        end else if (q_age[i] != AGE_W'(LATENCY)) begin
          q_age[i]   <= q_age[i] + AGE_W'(1);
        end
      end

      if (accept) tail <= ptr_inc(tail);
      if (retire) head <= ptr_inc(head);

      case ({accept, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      data_ok_q <= retire;
      if (retire) rdata_q <= q_wr[head] ? '0 : mem[q_idx[head]];
    end
  end

  // Memory has no reset so retired writes survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (resetn && retire && q_wr[head]) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (q_wstrb[head][b]) mem[q_idx[head]][8*b +: 8] <= q_wdata[head][8*b +: 8];
      end
    end
  end

  // Size and the ignored address bits are accepted but never affect data.
  always_comb begin
    unused_bits = ^bus.data_sram_addr;
    for (int unsigned i = 0; i < DEPTH; i++) unused_bits = unused_bits ^ (^q_size[i]);
  end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic stall;

  data_sram_if bus ();
  data_sram_if bus4 ();

  data_sram_responder #(.ADDR_WIDTH(10), .DEPTH(2), .LATENCY(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .resp_stall (stall),
    .bus        (bus.slave)
  );

  data_sram_responder #(.ADDR_WIDTH(10), .DEPTH(2), .LATENCY(4)) dut4 (
    .clk        (clk),
    .resetn     (resetn),
    .resp_stall (stall),
    .bus        (bus4.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle on the default-parameter instance: drive just after the edge,
  // check addr_ok/data_ok (and rdata when data_ok is expected) at negedge.
  task automatic cyc(input string tag, input bit rst, input bit stl,
                     input bit req, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     input bit eaok, input bit edok, input logic [31:0] erd);
    @(posedge clk);
    #1;
    resetn               = ~rst;
    stall                = stl;
    bus.data_sram_req    = req;
    bus.data_sram_wr     = wr;
    bus.data_sram_size   = 2'd2;
    bus.data_sram_addr   = addr;
    bus.data_sram_wdata  = wdata;
    bus.data_sram_wstrb  = wstrb;
    @(negedge clk);
    check({tag, ".addr_ok"}, {31'd0, bus.data_sram_addr_ok}, {31'd0, eaok});
    check({tag, ".data_ok"}, {31'd0, bus.data_sram_data_ok}, {31'd0, edok});
    if (edok) check({tag, ".rdata"}, bus.data_sram_rdata, erd);
  endtask

  bit exp_aok4 [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  bit exp_dok4 [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0};

  initial begin
    int k;
    resetn = 1'b0;
    stall  = 1'b0;
    bus.data_sram_req   = 1'b0;  bus4.data_sram_req   = 1'b0;
    bus.data_sram_wr    = 1'b0;  bus4.data_sram_wr    = 1'b0;
    bus.data_sram_size  = 2'd2;  bus4.data_sram_size  = 2'd2;
    bus.data_sram_addr  = '0;    bus4.data_sram_addr  = '0;
    bus.data_sram_wdata = '0;    bus4.data_sram_wdata = '0;
    bus.data_sram_wstrb = '0;    bus4.data_sram_wstrb = '0;
    repeat (3) @(posedge clk);

    // Reset state
    cyc("reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("reset.rdata", bus.data_sram_rdata, 32'h0);
    check("reset4.data_ok", {31'd0, bus4.data_sram_data_ok}, 32'd0);
    check("reset4.addr_ok", {31'd0, bus4.data_sram_addr_ok}, 32'd1);

    // T3: LATENCY=4, DEPTH=2, three writes held back-to-back
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      bus4.data_sram_req   = (k < 3);
      bus4.data_sram_wr    = 1'b1;
      bus4.data_sram_addr  = 32'(k * 4);
      bus4.data_sram_wdata = 32'(k);
      bus4.data_sram_wstrb = 4'hF;
      @(negedge clk);
      check($sformatf("t3.c%0d.addr_ok", c), {31'd0, bus4.data_sram_addr_ok}, {31'd0, exp_aok4[c]});
      check($sformatf("t3.c%0d.data_ok", c), {31'd0, bus4.data_sram_data_ok}, {31'd0, exp_dok4[c]});
      if (exp_dok4[c]) check($sformatf("t3.c%0d.rdata", c), bus4.data_sram_rdata, 32'h0);
      if (bus4.data_sram_req && bus4.data_sram_addr_ok) k++;
    end
    bus4.data_sram_req = 1'b0;
    check("t3.accepted", 32'(k), 32'd3);

    // T1: write then read same word
    cyc("t1.c0", 0, 0, 1, 1, 32'h100, 32'h12345678, 4'hF, 1, 0, 0);
    cyc("t1.c1", 0, 0, 1, 0, 32'h100, 32'h0, 4'h0, 1, 0, 0);
    cyc("t1.c2", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0);
    cyc("t1.c3", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h12345678);
    cyc("t1.c4", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // T2: partial byte write through wstrb
    cyc("t2.c0", 0, 0, 1, 1, 32'h102, 32'hAAAAAAAA, 4'b0010, 1, 0, 0);
    cyc("t2.c1", 0, 0, 1, 0, 32'h100, 32'h0, 4'h0, 1, 0, 0);
    cyc("t2.c2", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0);
    cyc("t2.c3", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234AA78);

    // T4: backpressure
    for (int i = 0; i < 3; i++)
      cyc($sformatf("t4.stall%0d", i), 0, 1, 1, 0, 32'h100, 0, 0, 0, 0, 0);
    cyc("t4.go", 0, 0, 1, 0, 32'h100, 0, 0, 1, 0, 0);
    cyc("t4.w1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("t4.w2", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234AA78);

    // T5: reset with reads outstanding; retired write survives
    cyc("t5.wr", 0, 0, 1, 1, 32'h40, 32'hCAFEF00D, 4'hF, 1, 0, 0);
    cyc("t5.i0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("t5.i1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0);
    cyc("t5.i2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("t5.rd0", 0, 0, 1, 0, 32'h100, 0, 0, 1, 0, 0);
    cyc("t5.rd1", 1, 0, 1, 0, 32'h104, 0, 0, 1, 0, 0);
    cyc("t5.rel", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("t5.rel.rdata", bus.data_sram_rdata, 32'h0);
    cyc("t5.q0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("t5.q1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("t5.rd2", 0, 0, 1, 0, 32'h40, 0, 0, 1, 0, 0);
    cyc("t5.w1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("t5.w2", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D);

    // T6: address aliasing above ADDR_WIDTH+1, then a zero-strobe write
    cyc("t6.wr", 0, 0, 1, 1, 32'h1000, 32'h11111111, 4'hF, 1, 0, 0);
    cyc("t6.rd", 0, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0);
    cyc("t6.r0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0);
    cyc("t6.r1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11111111);
    cyc("t6.wz", 0, 0, 1, 1, 32'h0, 32'hFFFFFFFF, 4'h0, 1, 0, 0);
    cyc("t6.rz", 0, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0);
    cyc("t6.z0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0);
    cyc("t6.z1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h11111111);
    cyc("t6.end", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
